// File: rtl/adc_cap_pkg.sv
// Shared defaults and FSM state type for the ADC capture block.
package adc_cap_pkg;

  localparam int unsigned CAP_DEPTH   = 640;
  localparam int unsigned CAP_DATA_W  = 8;
  localparam int unsigned CAP_DIV_W   = 16;
  localparam int unsigned CAP_TIMEOUT = 4096;
  localparam int unsigned CAP_ADDR_W  = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DONE
  } cap_state_e;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: synchronous write, registered read.
// Reads beyond the last entry return zero.
module capture_ram
  import adc_cap_pkg::*;
#(
  parameter int unsigned DEPTH  = CAP_DEPTH,
  parameter int unsigned DATA_W = CAP_DATA_W,
  parameter int unsigned ADDR_W = CAP_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port; array has no reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i && (waddr_i <= LAST)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port, cleared by reset, zero for out-of-range addresses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (raddr_i <= LAST) begin
      rdata_q <= mem_q[raddr_i];
    end else begin
      rdata_q <= '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/adc_capture.sv
// Oscilloscope-style ADC capture: free-running sample divider driving
// AD_CLK, edge/timeout trigger FSM, and a DEPTH-entry capture buffer.
module adc_capture
  import adc_cap_pkg::*;
#(
  parameter int unsigned DEPTH   = CAP_DEPTH,
  parameter int unsigned DATA_W  = CAP_DATA_W,
  parameter int unsigned DIV_W   = CAP_DIV_W,
  parameter int unsigned TIMEOUT = CAP_TIMEOUT
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] ad_data,
  output logic              AD_CLK,
  input  logic              arm,
  input  logic              auto_en,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [DIV_W-1:0]  div,
  input  logic [9:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              trig_auto
);

  localparam int unsigned       ADDR_W  = 10;
  localparam int unsigned       TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] WA_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT);

  // Divider
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] per_q, per_d;
  logic [DIV_W:0]   half_d;
  logic             ad_clk_q, ad_clk_d;
  logic             strobe;

  // Sample stage
  logic              smp_stb_q;
  logic [DATA_W-1:0] sample_q;

  // FSM
  cap_state_e        state_q;
  logic [DATA_W-1:0] last_q;
  logic              valid_q;
  logic [TO_W-1:0]   to_q;
  logic [TO_W-1:0]   to_inc;
  logic [ADDR_W-1:0] wa_q;
  logic              busy_q, done_q, auto_q;
  logic              trig_edge, trig_to;

  // RAM write port
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;

  // Divider next state. The period is latched only at the wrap, so a new
  // div value never truncates or stretches the period in progress.
  always_comb begin
    strobe = (cnt_q == per_q);
    if (strobe) begin
      cnt_d = '0;
      per_d = div;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
      per_d = per_q;
    end
    half_d   = ({1'b0, per_d} + (DIV_W + 1)'(1)) >> 1;
    ad_clk_d = ({1'b0, cnt_d} < half_d);
  end

  // Divider counter, latched period and registered AD_CLK.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q    <= '0;
      per_q    <= '0;
      ad_clk_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      ad_clk_q <= ad_clk_d;
    end
  end

  // Register the ADC sample on each strobe; the FSM acts one cycle later.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      smp_stb_q <= 1'b0;
      sample_q  <= '0;
    end else begin
      smp_stb_q <= strobe;
      if (strobe) begin
        sample_q <= ad_data;
      end
    end
  end

  // Trigger conditions and buffer write decode.
  always_comb begin
    to_inc    = to_q + TO_W'(1);
    trig_edge = valid_q && (last_q < trig_level) && (sample_q >= trig_level);
    trig_to   = auto_en && (to_inc == TO_LAST);
    ram_we    = smp_stb_q && !arm &&
                (((state_q == ST_ARMED) && (trig_edge || trig_to)) ||
                 (state_q == ST_CAPTURE));
    ram_waddr = (state_q == ST_ARMED) ? '0 : wa_q;
  end

  // Capture FSM with registered status outputs; arm overrides everything.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      last_q  <= '0;
      valid_q <= 1'b0;
      to_q    <= '0;
      wa_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      auto_q  <= 1'b0;
    end else if (arm) begin
      state_q <= ST_ARMED;
      valid_q <= 1'b0;
      to_q    <= '0;
      wa_q    <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      auto_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (smp_stb_q) begin
            last_q  <= sample_q;
            valid_q <= 1'b1;
            to_q    <= auto_en ? to_inc : '0;
            if (trig_edge || trig_to) begin
              state_q <= ST_CAPTURE;
              wa_q    <= ADDR_W'(1);
              auto_q  <= !trig_edge;
            end
          end else if (!auto_en) begin
            to_q <= '0;
          end
        end
        ST_CAPTURE: begin
          if (smp_stb_q) begin
            wa_q <= wa_q + ADDR_W'(1);
            if (wa_q == WA_LAST) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  capture_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (sys_clk),
    .rst_i   (sys_rst),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (sample_q),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign AD_CLK    = ad_clk_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign trig_auto = auto_q;

endmodule

// File: tb/tb_adc_capture.sv
// Directed scenarios for adc_capture with a readback scoreboard.
module tb_adc_capture;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [7:0]  ad_data;
  logic        AD_CLK;
  logic        arm;
  logic        auto_en;
  logic [7:0]  trig_level;
  logic [15:0] div;
  logic [9:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        busy;
  logic        done;
  logic        trig_auto;

  int unsigned tc;
  int unsigned ramp_shift;
  bit          ramp_mode;
  logic [7:0]  const_val;

  int vectors;
  int miscompares;

  typedef struct {
    int unsigned addr;
    logic [7:0]  data;
  } exp_t;
  exp_t sb[$];

  adc_capture dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .ad_data    (ad_data),
    .AD_CLK     (AD_CLK),
    .arm        (arm),
    .auto_en    (auto_en),
    .trig_level (trig_level),
    .div        (div),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .trig_auto  (trig_auto)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
    tc++;
    ad_data = ramp_mode ? 8'(tc >> ramp_shift) : const_val;
  endtask

  task automatic arm_pulse();
    tc      = 0;
    ad_data = ramp_mode ? 8'(0) : const_val;
    arm     = 1'b1;
    tick();
    arm     = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic push_expected(input int unsigned base, input bit constant);
    for (int unsigned a = 0; a < 640; a++) begin
      sb.push_back('{addr: a, data: constant ? 8'(base) : 8'(base + a)});
    end
    sb.push_back('{addr: 640, data: 8'h00});
    sb.push_back('{addr: 700, data: 8'h00});
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    #12;
    vectors++;
    if ({AD_CLK, busy, done, trig_auto} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 0000", {AD_CLK, busy, done, trig_auto});
    end
    vectors++;
    if (rd_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_rd_data: got %0h expected 0", rd_data);
    end
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_idle: busy/done got %b expected 00", {busy, done});
    end
  endtask

  task automatic test_ramp_div0();
    int n;
    bit clk_seen;
    div = 16'd0; trig_level = 8'd128; auto_en = 1'b0;
    ramp_mode = 1'b1; ramp_shift = 0;
    for (int i = 0; i < 8; i++) tick();
    clk_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (AD_CLK) clk_seen = 1'b1;
    end
    vectors++;
    if (clk_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL div0_adclk_low: got high expected low");
    end
    arm_pulse();
    vectors++;
    if ({busy, done} !== 2'b10) begin
      miscompares++;
      $display("FAIL ramp_armed: busy/done got %b expected 10", {busy, done});
    end
    wait_done(2000, n);
    vectors++;
    if (n != 768) begin
      miscompares++;
      $display("FAIL ramp_done_cycle: got %0d expected 768", n);
    end
    vectors++;
    if ({busy, done, trig_auto} !== 3'b010) begin
      miscompares++;
      $display("FAIL ramp_status: busy/done/auto got %b expected 010", {busy, done, trig_auto});
    end
    push_expected(128, 1'b0);
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      rd_addr = 10'(e.addr);
      tick();
      vectors++;
      if (rd_data !== e.data) begin
        miscompares++;
        $display("FAIL ramp_buf addr %0d: got %0h expected %0h", e.addr, rd_data, e.data);
      end
    end
  endtask

  task automatic test_div3();
    int n;
    int first;
    logic s[16];
    div = 16'd3; trig_level = 8'd128; auto_en = 1'b0;
    ramp_mode = 1'b1; ramp_shift = 2;
    for (int i = 0; i < 8; i++) tick();
    for (int i = 0; i < 16; i++) begin
      tick();
      s[i] = AD_CLK;
    end
    first = -1;
    for (int i = 1; i < 5; i++) begin
      if (first < 0 && s[i] === 1'b1 && s[i-1] === 1'b0) first = i;
    end
    vectors++;
    if (first < 0) begin
      miscompares++;
      $display("FAIL div3_adclk_rise: got none expected rising edge within 4 cycles");
    end else begin
      for (int j = 0; j < 12; j++) begin
        vectors++;
        if (s[first + j] !== ((j % 4) < 2)) begin
          miscompares++;
          $display("FAIL div3_adclk_shape phase %0d: got %b expected %b", j, s[first + j], (j % 4) < 2);
        end
      end
    end
    arm_pulse();
    wait_done(5000, n);
    vectors++;
    if (n < 3066 || n > 3076) begin
      miscompares++;
      $display("FAIL div3_done_cycle: got %0d expected 3066..3076", n);
    end
    push_expected(128, 1'b0);
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      rd_addr = 10'(e.addr);
      tick();
      vectors++;
      if (rd_data !== e.data) begin
        miscompares++;
        $display("FAIL div3_buf addr %0d: got %0h expected %0h", e.addr, rd_data, e.data);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    div = 16'd0; trig_level = 8'd128; auto_en = 1'b1;
    ramp_mode = 1'b0; const_val = 8'd10;
    for (int i = 0; i < 8; i++) tick();
    arm_pulse();
    wait_done(6000, n);
    vectors++;
    if (n != 4735) begin
      miscompares++;
      $display("FAIL timeout_done_cycle: got %0d expected 4735", n);
    end
    vectors++;
    if ({done, trig_auto} !== 2'b11) begin
      miscompares++;
      $display("FAIL timeout_status: done/auto got %b expected 11", {done, trig_auto});
    end
    push_expected(10, 1'b1);
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      rd_addr = 10'(e.addr);
      tick();
      vectors++;
      if (rd_data !== e.data) begin
        miscompares++;
        $display("FAIL timeout_buf addr %0d: got %0h expected %0h", e.addr, rd_data, e.data);
      end
    end
  endtask

  task automatic test_no_auto();
    bit done_seen;
    bit busy_drop;
    auto_en = 1'b0; ramp_mode = 1'b0; const_val = 8'd10;
    arm_pulse();
    vectors++;
    if ({busy, done, trig_auto} !== 3'b100) begin
      miscompares++;
      $display("FAIL noauto_arm_clears: busy/done/auto got %b expected 100", {busy, done, trig_auto});
    end
    done_seen = 1'b0;
    busy_drop = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (done) done_seen = 1'b1;
      if (!busy) busy_drop = 1'b1;
    end
    vectors++;
    if ({done_seen, busy_drop} !== 2'b00) begin
      miscompares++;
      $display("FAIL noauto_hold: done_seen/busy_drop got %b expected 00", {done_seen, busy_drop});
    end
  endtask

  task automatic test_abort();
    int m;
    div = 16'd0; trig_level = 8'd128; auto_en = 1'b0;
    ramp_mode = 1'b1; ramp_shift = 0;
    for (int i = 0; i < 8; i++) tick();
    arm_pulse();
    for (int i = 1; i <= 428; i++) tick();
    arm = 1'b1;
    trig_level = 8'd200;
    tick();
    arm = 1'b0;
    vectors++;
    if ({busy, done} !== 2'b10) begin
      miscompares++;
      $display("FAIL abort_rearm: busy/done got %b expected 10", {busy, done});
    end
    wait_done(2000, m);
    vectors++;
    if (m != 667) begin
      miscompares++;
      $display("FAIL abort_done_cycle: got %0d expected 667", m);
    end
    push_expected(200, 1'b0);
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      rd_addr = 10'(e.addr);
      tick();
      vectors++;
      if (rd_data !== e.data) begin
        miscompares++;
        $display("FAIL abort_buf addr %0d: got %0h expected %0h", e.addr, rd_data, e.data);
      end
    end
  endtask

  task automatic test_reset_mid_capture();
    div = 16'd3; trig_level = 8'd128; auto_en = 1'b0;
    ramp_mode = 1'b1; ramp_shift = 2;
    for (int i = 0; i < 8; i++) tick();
    arm_pulse();
    for (int i = 0; i < 1000; i++) tick();
    rd_addr = 10'd5;
    tick();
    vectors++;
    if ({busy, rd_data} !== {1'b1, 8'd133}) begin
      miscompares++;
      $display("FAIL midcap_pre: busy/rd_data got %b/%0h expected 1/85", busy, rd_data);
    end
    #2;
    sys_rst = 1'b1;
    #1;
    vectors++;
    if ({AD_CLK, busy, done, trig_auto, rd_data} !== 12'h000) begin
      miscompares++;
      $display("FAIL midcap_async_reset: clk/busy/done/auto/rd got %b%b%b%b/%0h expected 0000/0",
               AD_CLK, busy, done, trig_auto, rd_data);
    end
    tick();
    tick();
    sys_rst = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    vectors++;
    if ({busy, done, trig_auto} !== 3'b000) begin
      miscompares++;
      $display("FAIL midcap_idle: busy/done/auto got %b expected 000", {busy, done, trig_auto});
    end
    rd_addr = 10'd700;
    tick();
    vectors++;
    if (rd_data !== 8'h00) begin
      miscompares++;
      $display("FAIL midcap_rd700: got %0h expected 0", rd_data);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    tc          = 0;
    ramp_mode   = 1'b0;
    ramp_shift  = 0;
    const_val   = 8'd0;
    ad_data     = 8'd0;
    arm         = 1'b0;
    auto_en     = 1'b0;
    trig_level  = 8'd128;
    div         = 16'd0;
    rd_addr     = 10'd0;
    sys_rst     = 1'b1;

    test_reset();
    test_ramp_div0();
    test_div3();
    test_timeout();
    test_no_auto();
    test_abort();
    test_reset_mid_capture();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adc_capture.md
ADC_CAPTURE -- requirements
Module: adc_capture

Interface
REQ-001 Parameters SHALL be: DEPTH 640 (samples per capture, one per VGA column); DATA_W 8 (sample width); DIV_W 16 (sample-divider width); TIMEOUT 4096 (samples before auto-trigger).
REQ-002 Ports SHALL be, one per line:
  sys_clk  in  1  system clock, DAC/ADC domain
  sys_rst  in  1  asynchronous, active-high reset
  ad_data  in  DATA_W  ADC sample bus, unsigned offset-binary
  AD_CLK  out  1  ADC conversion clock
  arm  in  1  one-cycle pulse; starts or restarts a capture
  auto_en  in  1  enables timeout auto-trigger
  trig_level  in  DATA_W  rising-edge trigger threshold
  div  in  DIV_W  sample period minus one, in sys_clk cycles
  rd_addr  in  10  display read address
  rd_data  out  DATA_W  display read data
  busy  out  1  high in ARMED or CAPTURE
  done  out  1  buffer holds a complete capture
  trig_auto  out  1  last capture was auto-triggered

Function
REQ-003 A divider counter SHALL count 0..div and wrap; sample strobe SHALL assert for one cycle when counter equals div (div=0: every cycle).
REQ-004 AD_CLK SHALL be a registered output: high while counter < (div+1)/2, else low; for div=0 it SHALL be held low. The sample SHALL be registered from ad_data on each strobe.
REQ-005 FSM states SHALL be IDLE, ARMED, CAPTURE, DONE; the divider SHALL run free in all states.
REQ-006 IDLE/DONE --arm--> ARMED. On entry to ARMED, the sample-valid flag, timeout counter and write address SHALL be cleared.
REQ-007 In ARMED, a strobe with previous sample < trig_level and current sample >= trig_level SHALL go to CAPTURE. The first strobe after arming SHALL NOT trigger because no previous sample exists.
REQ-008 In ARMED with auto_en=1, the timeout counter SHALL count strobes; the strobe on which the count reaches TIMEOUT SHALL enter CAPTURE and set trig_auto. auto_en=0 SHALL hold the counter at 0.
REQ-009 The triggering strobe's sample SHALL be written to address 0. Each following strobe in CAPTURE SHALL write the next address. The write to DEPTH-1 SHALL move the FSM to DONE on the next cycle.
REQ-010 arm asserted in ARMED or CAPTURE SHALL abort and re-enter ARMED; done SHALL be low from the cycle after arm until the next capture completes. arm has priority over a simultaneous trigger or final write.
REQ-011 trig_auto SHALL be cleared on arm and set only per REQ-008.
REQ-012 Read latency SHALL be 1 cycle: rd_data reflects rd_addr from the previous edge. rd_addr >= DEPTH SHALL return 0. Reads SHALL always be permitted; contents are only coherent while done=1.
REQ-013 A change of div during a capture SHALL take effect at the next divider wrap; no strobe shall be dropped or duplicated.

Reset
REQ-014 sys_rst SHALL asynchronously force IDLE, divider=0, AD_CLK=0, busy=0, done=0, trig_auto=0, rd_data=0, timeout=0, write address=0. Buffer contents SHALL be undefined after reset.
REQ-015 Reset release mid-operation SHALL leave the block in IDLE until arm is asserted.

Structure
REQ-016 Package adc_cap_pkg SHALL hold the state enum and the DEPTH, DATA_W, DIV_W and TIMEOUT defaults.
REQ-017 The buffer SHALL be sub-module capture_ram: simple dual-port, DEPTH x DATA_W, synchronous write, registered read, inferable as block RAM.

Verification
REQ-018 Benches SHALL cover the following directed scenarios:
  - div=0, ramp 0..255 on ad_data, trig_level=128, arm -> addr0=128, addr639 = (128+639) mod 256 = 255, done=1, trig_auto=0.
  - div=3 -> strobes every 4 cycles; AD_CLK high 2 cycles, low 2 cycles; capture takes 640 x 4 cycles after trigger.
  - Constant ad_data=10, trig_level=128, auto_en=1 -> capture starts on strobe 4096 with trig_auto=1 and all entries 10; with auto_en=0 -> busy stays high and done never asserts.
  - arm pulsed at write address 300 -> FSM returns to ARMED, done stays low, the new capture rewrites from addr 0.
  - sys_rst asserted during CAPTURE -> all outputs zero asynchronously, IDLE after release; rd_addr=700 -> rd_data=0.
